// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port data memory (byte-enabled synchronous write,
// combinational read) between the instruction-fetch port (read-only) and the
// load/store port (read/write). Every access walks IDLE -> ACCESS -> RESP.
// Read data is registered at the end of ACCESS and returned with a one-cycle
// acknowledge pulse during RESP.
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until it sees its *_ack high for one cycle; *_rdata is valid in that cycle.
// Dropping a request before its ack is not allowed.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : IDLE contention grants the port that
//                                        was not served last.
//                           undefined : IDLE contention always grants the
//                                        load/store port (fixed priority).
//
// Parameters:
//   ADDR_WIDTH  requester address width (zero-extended onto mem_address)
//   CNT_WIDTH   width of the saturating contention counter
//
// Ports:
//   clock, reset_n                    clock, synchronous active-low reset
//   i_req, i_addr                     fetch request / address
//   i_ack, i_rdata                    fetch ack pulse / registered read data
//   d_req, d_we, d_addr, d_wdata, d_be load/store request, 1=store, address,
//                                     store data, store byte enables
//   d_ack, d_rdata                    load/store ack pulse / registered data
//   mem_address, mem_write_data,      memory address, write data,
//   mem_write_enable, store_enable    byte enables, write strobe
//   mem_read_data                     combinational memory read data
//   busy                              arbiter not idle
//   conflict_count                    saturating count of contention cycles
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   // fetch port
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_ack,
   output logic [31:0]           i_rdata,
   // load/store port
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [31:0]           d_wdata,
   input  logic [3:0]            d_be,
   output logic                  d_ack,
   output logic [31:0]           d_rdata,
   // memory side
   output logic [31:0]           mem_address,
   output logic [31:0]           mem_write_data,
   output logic [3:0]            mem_write_enable,
   output logic                  store_enable,
   input  logic [31:0]           mem_read_data,
   // status
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  conflict_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic                 PORT_I  = 1'b0;
   localparam logic                 PORT_D  = 1'b1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // arbitration state
   state_t               r_state;
   logic                 r_grant;
   logic                 r_last;
   logic [CNT_WIDTH-1:0] r_conflict_count;

   // memory-side registers; they hold their value outside ACCESS
   logic [31:0]          r_mem_address;
   logic [31:0]          r_mem_write_data;
   logic [3:0]           r_mem_be;

   // read data returned to the requesters
   logic [31:0]          r_i_rdata;
   logic [31:0]          r_d_rdata;

   // next-state decode
   state_t               w_next_state;
   logic                 w_next_grant;
   logic                 w_start;      // a new access begins next cycle
   logic                 w_conflict;   // both ports requesting in IDLE
   logic                 w_contend_win;

   // source of the access being launched
   logic [31:0]          w_src_addr;
   logic [31:0]          w_src_wdata;
   logic [3:0]           w_src_be;

   // Contention winner. In the fixed-priority build r_last is still tracked
   // but does not influence arbitration.
`ifdef MEM_ARB_ROUND_ROBIN_EN
   assign w_contend_win = ~r_last;
`else
   assign w_contend_win = PORT_D;
`endif

   // -------------------------------------------------------------------------
   // Next-state / grant decode
   // -------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_next_grant = r_grant;
      w_start      = 1'b0;
      w_conflict   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_req && d_req) begin
               w_conflict   = 1'b1;
               w_start      = 1'b1;
               w_next_grant = w_contend_win;
               w_next_state = ST_ACCESS;
            end else if (d_req) begin
               w_start      = 1'b1;
               w_next_grant = PORT_D;
               w_next_state = ST_ACCESS;
            end else if (i_req) begin
               w_start      = 1'b1;
               w_next_grant = PORT_I;
               w_next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            w_next_state = ST_RESP;
         end
         ST_RESP: begin
            // The acked port still holds its request this cycle, so only the
            // other port is considered for a direct hand-off.
            if ((r_grant == PORT_I) ? d_req : i_req) begin
               w_start      = 1'b1;
               w_next_grant = ~r_grant;
               w_next_state = ST_ACCESS;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Fetch accesses never write: data and byte enables are forced to zero.
   assign w_src_addr  = (w_next_grant == PORT_D) ? 32'(d_addr) : 32'(i_addr);
   assign w_src_wdata = (w_next_grant == PORT_D) ? d_wdata : 32'd0;
   assign w_src_be    = (w_next_grant == PORT_D) ? d_be : 4'd0;

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state          <= ST_IDLE;
         r_grant          <= PORT_I;
         r_last           <= PORT_I;
         r_conflict_count <= '0;
         r_mem_address    <= 32'd0;
         r_mem_write_data <= 32'd0;
         r_mem_be         <= 4'd0;
         r_i_rdata        <= 32'd0;
         r_d_rdata        <= 32'd0;
      end else begin
         r_state <= w_next_state;
         r_grant <= w_next_grant;

         if (r_state == ST_RESP) begin
            r_last <= r_grant;
         end

         // Address/data are latched as the access is launched so they are
         // stable for the whole ACCESS cycle and hold afterwards.
         if (w_start) begin
            r_mem_address    <= w_src_addr;
            r_mem_write_data <= w_src_wdata;
            r_mem_be         <= w_src_be;
         end

         // Read data is captured for stores too; it is the pre-write value
         // because the memory write lands on this same edge.
         if (r_state == ST_ACCESS) begin
            if (r_grant == PORT_D) begin
               r_d_rdata <= mem_read_data;
            end else begin
               r_i_rdata <= mem_read_data;
            end
         end

         if (w_conflict && (r_conflict_count != CNT_MAX)) begin
            r_conflict_count <= r_conflict_count + CNT_WIDTH'(1);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign i_ack            = (r_state == ST_RESP) && (r_grant == PORT_I);
   assign d_ack            = (r_state == ST_RESP) && (r_grant == PORT_D);
   assign i_rdata          = r_i_rdata;
   assign d_rdata          = r_d_rdata;
   assign busy             = (r_state != ST_IDLE);
   assign conflict_count   = r_conflict_count;
   assign mem_address      = r_mem_address;
   assign mem_write_data   = r_mem_write_data;
   assign mem_write_enable = (r_state == ST_ACCESS) ? r_mem_be : 4'd0;
   // Gated by reset_n so a reset edge in the middle of a store never writes.
   assign store_enable     = (r_state == ST_ACCESS) && (r_grant == PORT_D) &&
                             d_we && reset_n;

endmodule
